// File: rtl/sprite_anim_mapper.sv
// Sprite renderer for the VGA pixel path: maps screen coordinates into a multi-frame sprite ROM.
// It applies scale and horizontal flip, resolves transparency and registers 12-bit RGB three cycles after DrawX/DrawY.
module sprite_anim_mapper #(
    parameter int SPR_W       = 21,
    parameter int SPR_H       = 45,
    parameter int NUM_FRAMES  = 4,
    parameter int SCALE_LOG2  = 1,
    parameter int FRAME_TICKS = 8,
    parameter int ADDR_W      = 12,
    parameter int IDX_W       = 5,
    parameter int TRANSP_IDX  = 0,
    localparam int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              flip_h,
    input  logic              anim_en,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [FRAME_W-1:0] frame_sel,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
);

    localparam int TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int PIX_W      = SPR_W << SCALE_LOG2;
    localparam int PIX_H      = SPR_H << SCALE_LOG2;
    localparam int FRAME_SIZE = SPR_W * SPR_H;

    logic [9:0]         r_spos_x;
    logic [9:0]         r_spos_y;
    logic               r_sflip;
    logic [TICK_W-1:0]  r_tick;
    logic [FRAME_W-1:0] r_frame_sel;

    logic [ADDR_W-1:0]  r_rom_address;
    logic               r_hit_a;
    logic               r_blank_a;
    logic [11:0]        r_bg_a;
    logic               r_hit_b;
    logic               r_blank_b;
    logic [11:0]        r_bg_b;
    logic [11:0]        r_rgb;

    logic [10:0]        w_lx;
    logic [10:0]        w_ly;
    logic               w_hit;
    logic [9:0]         w_col;
    logic [9:0]         w_row;
    logic [9:0]         w_col_eff;
    logic [ADDR_W-1:0]  w_addr;

    // Local offsets are 11-bit two's complement; bit 10 set means left of / above the sprite.
    always_comb begin
        w_lx      = {1'b0, DrawX} - {1'b0, r_spos_x};
        w_ly      = {1'b0, DrawY} - {1'b0, r_spos_y};
        w_hit     = !w_lx[10] && !w_ly[10] && (w_lx < 11'(PIX_W)) && (w_ly < 11'(PIX_H));
        w_col     = w_lx[9:0] >> SCALE_LOG2;
        w_row     = w_ly[9:0] >> SCALE_LOG2;
        w_col_eff = r_sflip ? (10'(SPR_W - 1) - w_col) : w_col;
        w_addr    = ADDR_W'(r_frame_sel) * ADDR_W'(FRAME_SIZE)
                  + ADDR_W'(w_row) * ADDR_W'(SPR_W)
                  + ADDR_W'(w_col_eff);
    end

    // Shadow registers and animation counters all update on the frame_start edge.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_spos_x    <= '0;
            r_spos_y    <= '0;
            r_sflip     <= 1'b0;
            r_tick      <= '0;
            r_frame_sel <= '0;
        end else if (frame_start) begin
            r_spos_x <= pos_x;
            r_spos_y <= pos_y;
            r_sflip  <= flip_h;
            if (anim_en) begin
                if (r_tick == TICK_W'(FRAME_TICKS - 1)) begin
                    r_tick <= '0;
                    if (r_frame_sel == FRAME_W'(NUM_FRAMES - 1))
                        r_frame_sel <= '0;
                    else
                        r_frame_sel <= r_frame_sel + 1'b1;
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_rom_address <= '0;
            r_hit_a       <= 1'b0;
            r_blank_a     <= 1'b0;
            r_bg_a        <= '0;
            r_hit_b       <= 1'b0;
            r_blank_b     <= 1'b0;
            r_bg_b        <= '0;
            r_rgb         <= '0;
        end else begin
            if (w_hit)
                r_rom_address <= w_addr;
            r_hit_a   <= w_hit;
            r_blank_a <= blank;
            r_bg_a    <= {bg_red, bg_green, bg_blue};
            // Delay one more cycle so hit/blank/bg line up with rom_q.
            r_hit_b   <= r_hit_a;
            r_blank_b <= r_blank_a;
            r_bg_b    <= r_bg_a;
            if (!r_blank_b)
                r_rgb <= '0;
            else if (!r_hit_b || (rom_q == IDX_W'(TRANSP_IDX)))
                r_rgb <= r_bg_b;
            else
                r_rgb <= {pal_red, pal_green, pal_blue};
        end
    end

    assign rom_address = r_rom_address;
    assign pal_index   = rom_q;
    assign frame_sel   = r_frame_sel;
    assign red         = r_rgb[11:8];
    assign green       = r_rgb[7:4];
    assign blue        = r_rgb[3:0];

endmodule

// File: tb/tb_sprite_anim_mapper.sv
// Directed bench for sprite_anim_mapper: reset flush, hit/scale mapping, flip, transparency,
// animation stepping, shadow-register timing, clipping and mid-line reset.
module tb_sprite_anim_mapper;

    logic        clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank, frame_start;
    logic [9:0]  pos_x, pos_y;
    logic        flip_h, anim_en;
    logic [3:0]  bg_red, bg_green, bg_blue;
    logic [11:0] rom_address;
    logic [4:0]  rom_q;
    logic [4:0]  pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic [1:0]  frame_sel;
    logic [3:0]  red, green, blue;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_anim_mapper dut (
        .vga_clk(clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
        .flip_h(flip_h), .anim_en(anim_en),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .frame_sel(frame_sel), .red(red), .green(green), .blue(blue)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance n clock edges; returns at the following falling edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pix(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        cyc(1);
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        cyc(1);
    endtask

    task automatic latch(input int x, input int y, input logic f);
        pos_x  = 10'(x);
        pos_y  = 10'(y);
        flip_h = f;
        pulse();
    endtask

    function automatic logic [31:0] rgb();
        return {20'd0, red, green, blue};
    endfunction

    initial begin
        Reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b1; frame_start = 1'b0;
        pos_x = '0; pos_y = '0; flip_h = 1'b0; anim_en = 1'b0;
        bg_red = 4'h3; bg_green = 4'h4; bg_blue = 4'h5;
        rom_q = 5'd7; pal_red = 4'h1; pal_green = 4'h2; pal_blue = 4'h3;

        // Reset flush
        cyc(1);
        chk("rst_rgb0", rgb(), 0);
        chk("rst_fsel0", 32'(frame_sel), 0);
        cyc(1);
        chk("rst_rgb1", rgb(), 0);
        chk("rst_fsel1", 32'(frame_sel), 0);
        chk("rst_addr", 32'(rom_address), 0);
        chk("pal_index", 32'(pal_index), 7);
        Reset = 1'b0;
        cyc(1);
        chk("flush_c1", rgb(), 0);
        cyc(1);
        chk("flush_c2", rgb(), 0);
        cyc(1);
        chk("flush_c3", rgb(), 32'h123);

        // Hit / scale
        latch(100, 50, 1'b0);
        pix(101, 51);  chk("hit_101_51", 32'(rom_address), 0);
        pix(141, 51);  chk("hit_141_51", 32'(rom_address), 20);
        pix(100, 52);  chk("hit_100_52", 32'(rom_address), 21);
        rom_q = 5'd9; pal_red = 4'hF; pal_green = 4'hF; pal_blue = 4'hF;
        pix(142, 50);  chk("miss_hold", 32'(rom_address), 21);
        cyc(2);        chk("miss_bg", rgb(), 32'h345);
        pix(99, 50);   chk("miss_left", 32'(rom_address), 21);
        pix(100, 49);  chk("miss_above", 32'(rom_address), 21);
        pix(100, 140); chk("miss_below", 32'(rom_address), 21);
        pix(100, 139); chk("last_row", 32'(rom_address), 924);

        // Flip
        latch(100, 50, 1'b1);
        pix(100, 50);  chk("flip_100", 32'(rom_address), 20);
        pix(141, 50);  chk("flip_141", 32'(rom_address), 0);
        pix(141, 139); chk("flip_corner", 32'(rom_address), 924);

        // Transparency and blanking
        DrawX = 10'd100; DrawY = 10'd50;
        rom_q = 5'd0;
        cyc(3);        chk("transp_bg", rgb(), 32'h345);
        rom_q = 5'd3; pal_red = 4'hF; pal_green = 4'h0; pal_blue = 4'hA;
        cyc(3);        chk("opaque_pal", rgb(), 32'hF0A);
        blank = 1'b0;
        cyc(3);        chk("blank_black", rgb(), 0);
        blank = 1'b1;

        // Animation
        latch(100, 50, 1'b0);
        anim_en = 1'b1;
        for (int i = 0; i < 7; i++) pulse();
        chk("anim_7", 32'(frame_sel), 0);
        pulse();
        chk("anim_8", 32'(frame_sel), 1);
        pix(100, 50);  chk("anim_addr1", 32'(rom_address), 945);
        for (int i = 0; i < 8; i++) pulse();
        chk("anim_16", 32'(frame_sel), 2);
        for (int i = 0; i < 16; i++) pulse();
        chk("anim_32", 32'(frame_sel), 0);
        for (int i = 0; i < 8; i++) pulse();
        chk("anim_40", 32'(frame_sel), 1);
        anim_en = 1'b0;
        for (int i = 0; i < 8; i++) pulse();
        chk("anim_hold", 32'(frame_sel), 1);
        anim_en = 1'b1;
        for (int i = 0; i < 8; i++) pulse();
        chk("anim_resume", 32'(frame_sel), 2);
        anim_en = 1'b0;
        pix(100, 50);  chk("anim_addr2", 32'(rom_address), 1890);

        // Shadowing
        pos_x = 10'd200;
        pix(120, 50);  chk("shadow_old", 32'(rom_address), 1900);
        pulse();
        pix(120, 50);  chk("shadow_miss", 32'(rom_address), 1900);
        pix(204, 50);  chk("shadow_new", 32'(rom_address), 1892);
        pos_x = 10'd300; frame_start = 1'b1;
        pix(206, 50);  chk("shadow_edge", 32'(rom_address), 1893);
        frame_start = 1'b0;
        pix(306, 50);  chk("shadow_300", 32'(rom_address), 1893);
        pix(310, 50);  chk("shadow_300b", 32'(rom_address), 1895);

        // Off-screen clipping
        latch(630, 50, 1'b0);
        pix(639, 50);  chk("clip_639", 32'(rom_address), 1894);
        pix(0, 50);    chk("clip_nowrap", 32'(rom_address), 1894);

        // Mid-line reset
        pix(630, 50);
        cyc(2);        chk("pre_rst_rgb", rgb(), 32'hF0A);
        Reset = 1'b1;
        cyc(1);
        chk("mid_rst_rgb", rgb(), 0);
        chk("mid_rst_addr", 32'(rom_address), 0);
        chk("mid_rst_fsel", 32'(frame_sel), 0);
        Reset = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0;
        cyc(2);        chk("post_rst_c2", rgb(), 0);
        cyc(1);        chk("post_rst_c3", rgb(), 32'hF0A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
